// File: rtl/piano_pkg.sv
// Shared definitions for the melody recorder: entry format, note codes,
// mode encodings, controller states and key/note conversion helpers.
package piano_pkg;

   localparam int         ENTRY_W   = 13;
   localparam logic [4:0] NOTE_REST = 5'd16;
   localparam logic [7:0] DUR_MAX   = 8'd255;

   // Encoding seen on the mode output.
   typedef enum logic [1:0] {
      MODE_LIVE = 2'd0,
      MODE_REC  = 2'd1,
      MODE_PLAY = 2'd2
   } mode_e;

   // Controller states; both PLAY_* states report MODE_PLAY.
   typedef enum logic [1:0] {
      ST_LIVE,
      ST_REC,
      ST_PLAY_FETCH,
      ST_PLAY_HOLD
   } state_e;

   // One buffer entry: note code (0..15 or REST) and duration in ticks.
   typedef struct packed {
      logic [4:0] code;
      logic [7:0] dur;
   } entry_t;

   // Lowest held key wins when several keys are down; no key gives REST.
   function automatic logic [4:0] key_code(input logic [15:0] keys);
      logic [4:0] code;
      code = NOTE_REST;
      for (int i = 15; i >= 0; i--) begin
         if (keys[i]) code = 5'(i);
      end
      return code;
   endfunction

   // One-hot beeper vector for a note code; REST (or anything above 15) is silence.
   function automatic logic [15:0] code_onehot(input logic [4:0] code);
      logic [15:0] vec;
      vec = '0;
      if (code < NOTE_REST) vec[code[3:0]] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/melody_recorder_tick_gen.sv
// Duration tick generator: counts TICK_DIV clock cycles and pulses tick for
// one cycle on the last count. restart forces the count back to zero so a
// new note or playback entry starts on a clean tick boundary.
module tick_gen #(
   parameter int TICK_DIV = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: wrap on the last count, or jump to zero on restart.
   always_comb begin
      if (restart || (cnt_q == CNT_LAST)) cnt_d = '0;
      else                                cnt_d = cnt_q + CNT_W'(1);
   end

   assign tick = (cnt_q == CNT_LAST);

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/melody_recorder.sv
// Record/playback controller sitting between the key scanner and the beeper.
// LIVE and REC pass the held keys through (registered); REC also logs
// {code, duration} entries; PLAY replays the buffer and owns note_out.
module melody_recorder
   import piano_pkg::*;
#(
   parameter int TICK_DIV = 500000,
   parameter int DEPTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              live_keys,
   input  logic [15:0]              key_pulse,
   input  logic                     rec_req,
   input  logic                     play_req,
   input  logic                     stop_req,
   output logic [15:0]              note_out,
   output logic [1:0]               mode,
   output logic [$clog2(DEPTH):0]   rec_count,
   output logic                     full
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   // Controller state and registered datapath.
   state_e           state_q, state_d;
   logic [15:0]      note_q, note_d;
   logic [CNT_W-1:0] rec_count_q, rec_count_d;
   logic             full_q, full_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]       ticks_q, ticks_d;
   logic             open_valid_q, open_valid_d;
   logic [4:0]       open_code_q, open_code_d;
   logic             wr_en_q, wr_en_d;
   logic [AW-1:0]    wr_addr_q, wr_addr_d;
   entry_t           wr_data_q, wr_data_d;

   // Buffer storage and its synchronous read port.
   entry_t           mem_q [DEPTH];
   entry_t           rd_data_q;

   // Decoded events shared by next-state and datapath logic.
   logic             tick;
   logic             tick_restart;
   logic [4:0]       cur_code;
   logic [7:0]       ticks_now;
   logic             rec_change;
   logic             rec_flush;
   logic             rec_write;
   logic             rec_fills;
   logic             hold_done;
   logic             last_entry;
   logic             abort;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .restart (tick_restart),
      .tick    (tick)
   );

   // Decode recording and playback events from current state and inputs.
   always_comb begin
      cur_code   = key_code(live_keys);
      // Ticks completed so far, counting a tick landing in this very cycle.
      ticks_now  = ticks_q + 8'(tick);
      rec_change = open_valid_q && ((cur_code != open_code_q) || (ticks_now == DUR_MAX));
      // A trailing REST is never stored, so only a note is flushed on stop.
      rec_flush  = open_valid_q && (open_code_q != NOTE_REST);
      rec_write  = (state_q == ST_REC) && (stop_req ? rec_flush : rec_change);
      rec_fills  = rec_write && (rec_count_q == CNT_W'(DEPTH - 1));
      hold_done  = (state_q == ST_PLAY_HOLD) && tick && (ticks_now >= rd_data_q.dur);
      last_entry = ({1'b0, rd_ptr_q} == (rec_count_q - CNT_W'(1)));
      abort      = stop_req || (|key_pulse);
   end

   // Next-state logic; stop beats rec beats play.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LIVE: begin
            if (stop_req)                             state_d = ST_LIVE;
            else if (rec_req)                         state_d = ST_REC;
            else if (play_req && (rec_count_q != '0)) state_d = ST_PLAY_FETCH;
         end
         ST_REC: begin
            if (stop_req || rec_fills) state_d = ST_LIVE;
         end
         ST_PLAY_FETCH: begin
            state_d = abort ? ST_LIVE : ST_PLAY_HOLD;
         end
         ST_PLAY_HOLD: begin
            if (abort)          state_d = ST_LIVE;
            else if (hold_done) state_d = last_entry ? ST_LIVE : ST_PLAY_FETCH;
         end
         default: state_d = ST_LIVE;
      endcase
   end

   // Outputs: the hold state drives the fetched note straight from the read
   // register so the first note appears the cycle after the fetch.
   always_comb begin
      note_out = (state_q == ST_PLAY_HOLD) ? code_onehot(rd_data_q.code) : note_q;
      case (state_q)
         ST_LIVE: mode = MODE_LIVE;
         ST_REC:  mode = MODE_REC;
         default: mode = MODE_PLAY;
      endcase
   end

   assign rec_count = rec_count_q;
   assign full      = full_q;

   // Datapath next values: recording entries, playback pointer, tick count.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      rec_count_d    = rec_count_q;
      full_d         = full_q;
      rd_ptr_d       = rd_ptr_q;
      ticks_d        = ticks_q;
      open_valid_d   = open_valid_q;
      open_code_d    = open_code_q;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      tick_restart   = 1'b0;

      case (state_q)
         ST_LIVE: begin
            if (!stop_req && rec_req) begin
               rec_count_d  = '0;
               full_d       = 1'b0;
               open_valid_d = 1'b0;
               ticks_d      = '0;
               tick_restart = 1'b1;
            end else if (!stop_req && play_req && (rec_count_q != '0)) begin
               rd_ptr_d = '0;
            end
         end

         ST_REC: begin
            // Closing entry is written one cycle later from the write register.
            if (rec_write) begin
               wr_en_d        = 1'b1;
               wr_addr_d      = rec_count_q[AW-1:0];
               wr_data_d.code = open_code_q;
               wr_data_d.dur  = (ticks_now == 8'd0) ? 8'd1 : ticks_now;
               rec_count_d    = rec_count_q + CNT_W'(1);
               if (rec_fills) full_d = 1'b1;
            end
            if (stop_req || rec_fills) begin
               open_valid_d = 1'b0;
            end else if (!open_valid_q) begin
               // Leading silence is skipped; the first note opens the first entry.
               if (cur_code != NOTE_REST) begin
                  open_valid_d = 1'b1;
                  open_code_d  = cur_code;
                  ticks_d      = '0;
                  tick_restart = 1'b1;
               end
            end else if (rec_change) begin
               open_code_d  = cur_code;
               ticks_d      = '0;
               tick_restart = 1'b1;
            end else begin
               ticks_d = ticks_now;
            end
         end

         ST_PLAY_FETCH: begin
            ticks_d      = '0;
            tick_restart = 1'b1;
         end

         ST_PLAY_HOLD: begin
            if (tick) ticks_d = ticks_now;
            if (hold_done && !last_entry) rd_ptr_d = rd_ptr_q + AW'(1);
         end

         default: ;
      endcase
   end

   // Registered beeper value: live keys whenever the next state passes them
   // through, otherwise the last played note so a fetch cycle holds it.
   always_comb begin
      note_d = note_q;
      if (state_q == ST_PLAY_HOLD) note_d = code_onehot(rd_data_q.code);
      if ((state_d == ST_LIVE) || (state_d == ST_REC)) note_d = live_keys;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LIVE;
         note_q       <= '0;
         rec_count_q  <= '0;
         full_q       <= 1'b0;
         rd_ptr_q     <= '0;
         ticks_q      <= '0;
         open_valid_q <= 1'b0;
         open_code_q  <= NOTE_REST;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         note_q       <= note_d;
         rec_count_q  <= rec_count_d;
         full_q       <= full_d;
         rd_ptr_q     <= rd_ptr_d;
         ticks_q      <= ticks_d;
         open_valid_q <= open_valid_d;
         open_code_q  <= open_code_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   // Entry buffer: registered write port, read register loaded in PLAY_FETCH.
   always_ff @(posedge clk) begin
      // NOTE: the buffer has no reset so it maps onto block RAM; rec_count marks valid entries.
      if (wr_en_q) mem_q[wr_addr_q] <= wr_data_q;
      if (state_q == ST_PLAY_FETCH) rd_data_q <= mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_melody_recorder.sv
// Directed bench for melody_recorder with TICK_DIV = 4, DEPTH = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_melody_recorder;

   localparam int TICK_DIV = 4;
   localparam int DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] live_keys;
   logic [15:0] key_pulse;
   logic        rec_req;
   logic        play_req;
   logic        stop_req;
   logic [15:0] note_out;
   logic [1:0]  mode;
   logic [2:0]  rec_count;
   logic        full;

   int checks = 0;
   int errors = 0;

   melody_recorder #(
      .TICK_DIV (TICK_DIV),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .live_keys (live_keys),
      .key_pulse (key_pulse),
      .rec_req   (rec_req),
      .play_req  (play_req),
      .stop_req  (stop_req),
      .note_out  (note_out),
      .mode      (mode),
      .rec_count (rec_count),
      .full      (full)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; live_keys = '0; key_pulse = '0;
      rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
      step(3);
      checks++; if (note_out !== 16'h0000) begin errors++; $display("FAIL reset_note: got %h want %h", note_out, 16'h0000); end
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
      checks++; if (rec_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rec_count); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      rst = 1'b0;
      step(1);
      live_keys = 16'h0004;
      #1;
      checks++; if (note_out !== 16'h0000) begin errors++; $display("FAIL live_before_edge: got %h want %h", note_out, 16'h0000); end
      step(1);
      checks++; if (note_out !== 16'h0004) begin errors++; $display("FAIL live_pass: got %h want %h", note_out, 16'h0004); end
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL live_mode: got %0d want 0", mode); end
      checks++; if (rec_count !== 3'd0) begin errors++; $display("FAIL live_count: got %0d want 0", rec_count); end
      live_keys = '0;
      step(1);
   endtask

   task automatic test_play_empty();
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL play_empty_mode: got %0d want 0", mode); end
      step(1);
   endtask

   task automatic test_record_replay();
      logic [15:0] exp_seq [21];
      for (int i = 0; i < 21; i++) exp_seq[i] = (i < 13) ? 16'h0004 : 16'h0020;
      rec_req = 1'b1;
      step(1);
      rec_req = 1'b0;
      checks++; if (mode !== 2'd1) begin errors++; $display("FAIL rec_mode: got %0d want 1", mode); end
      live_keys = 16'h0004;
      step(1);
      checks++; if (note_out !== 16'h0004) begin errors++; $display("FAIL rec_pass: got %h want %h", note_out, 16'h0004); end
      step(11);
      live_keys = 16'h0020;
      play_req  = 1'b1;
      step(1);
      play_req  = 1'b0;
      checks++; if (mode !== 2'd1) begin errors++; $display("FAIL rec_ignores_play: got %0d want 1", mode); end
      step(7);
      stop_req = 1'b1;
      step(1);
      stop_req = 1'b0; live_keys = '0;
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rec_stop_mode: got %0d want 0", mode); end
      checks++; if (rec_count !== 3'd2) begin errors++; $display("FAIL rec_count_two: got %0d want 2", rec_count); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rec_not_full: got %b want 0", full); end
      step(1);
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      checks++; if (mode !== 2'd2) begin errors++; $display("FAIL play_fetch_mode: got %0d want 2", mode); end
      for (int i = 0; i < 21; i++) begin
         step(1);
         checks++;
         if (mode !== 2'd2 || note_out !== exp_seq[i]) begin
            errors++; $display("FAIL replay_seq[%0d]: got mode %0d note %h want mode 2 note %h", i, mode, note_out, exp_seq[i]);
         end
      end
      step(1);
      checks++; if (mode !== 2'd0 || note_out !== 16'h0000) begin errors++; $display("FAIL replay_end: got mode %0d note %h want mode 0 note 0000", mode, note_out); end
   endtask

   task automatic test_stop_priority();
      rec_req = 1'b1; stop_req = 1'b1;
      step(1);
      rec_req = 1'b0; stop_req = 1'b0;
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL stop_beats_rec_mode: got %0d want 0", mode); end
      checks++; if (rec_count !== 3'd2) begin errors++; $display("FAIL stop_beats_rec_count: got %0d want 2", rec_count); end
      step(1);
   endtask

   task automatic test_rest_multikey();
      rec_req = 1'b1;
      step(1);
      rec_req = 1'b0;
      live_keys = '0;
      step(5);
      checks++; if (rec_count !== 3'd0 || mode !== 2'd1) begin errors++; $display("FAIL lead_rest: got count %0d mode %0d want count 0 mode 1", rec_count, mode); end
      live_keys = 16'h0088;
      step(1);
      checks++; if (note_out !== 16'h0088) begin errors++; $display("FAIL multikey_pass: got %h want %h", note_out, 16'h0088); end
      step(7);
      stop_req = 1'b1;
      step(1);
      stop_req = 1'b0; live_keys = '0;
      checks++; if (rec_count !== 3'd1) begin errors++; $display("FAIL multikey_count: got %0d want 1", rec_count); end
      step(1);
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         checks++;
         if (mode !== 2'd2 || note_out !== 16'h0008) begin
            errors++; $display("FAIL multikey_play[%0d]: got mode %0d note %h want mode 2 note 0008", i, mode, note_out);
         end
      end
      step(1);
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL multikey_end: got %0d want 0", mode); end
   endtask

   task automatic test_note_rest_note();
      logic [15:0] exp_seq [14];
      for (int i = 0; i < 14; i++) exp_seq[i] = (i < 5) ? 16'h0002 : ((i < 10) ? 16'h0000 : 16'h0100);
      rec_req = 1'b1;
      step(1);
      rec_req = 1'b0;
      live_keys = 16'h0002;
      step(4);
      live_keys = 16'h0000;
      step(4);
      live_keys = 16'h0100;
      step(4);
      stop_req = 1'b1;
      step(1);
      stop_req = 1'b0; live_keys = '0;
      checks++; if (rec_count !== 3'd3) begin errors++; $display("FAIL nrn_count: got %0d want 3", rec_count); end
      step(1);
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      for (int i = 0; i < 14; i++) begin
         step(1);
         checks++;
         if (mode !== 2'd2 || note_out !== exp_seq[i]) begin
            errors++; $display("FAIL nrn_play[%0d]: got mode %0d note %h want mode 2 note %h", i, mode, note_out, exp_seq[i]);
         end
      end
      step(1);
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL nrn_end: got %0d want 0", mode); end
   endtask

   task automatic test_full();
      logic [15:0] key;
      rec_req = 1'b1;
      step(1);
      rec_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         key = 16'h0001 << i;
         live_keys = key;
         step(4);
      end
      checks++; if (rec_count !== 3'd3 || full !== 1'b0 || mode !== 2'd1) begin
         errors++; $display("FAIL full_before: got count %0d full %b mode %0d want 3 0 1", rec_count, full, mode);
      end
      live_keys = 16'h0010;
      step(1);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL full_mode: got %0d want 0", mode); end
      checks++; if (rec_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", rec_count); end
      checks++; if (note_out !== 16'h0010) begin errors++; $display("FAIL full_pass: got %h want %h", note_out, 16'h0010); end
      live_keys = 16'h0020;
      step(4);
      live_keys = '0;
      step(1);
      checks++; if (rec_count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_frozen: got count %0d full %b want 4 1", rec_count, full); end
   endtask

   task automatic test_abort();
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      step(1);
      rec_req = 1'b1;
      step(1);
      rec_req = 1'b0;
      checks++; if (mode !== 2'd2 || note_out !== 16'h0001) begin
         errors++; $display("FAIL play_ignores_rec: got mode %0d note %h want mode 2 note 0001", mode, note_out);
      end
      live_keys = 16'h0400; key_pulse = 16'h0400;
      step(1);
      key_pulse = '0;
      checks++; if (mode !== 2'd0 || note_out !== 16'h0400) begin
         errors++; $display("FAIL pulse_abort: got mode %0d note %h want mode 0 note 0400", mode, note_out);
      end
      checks++; if (rec_count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL abort_persist: got count %0d full %b want 4 1", rec_count, full); end
      live_keys = '0;
      step(1);
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      step(1);
      live_keys = 16'h0200; stop_req = 1'b1;
      step(1);
      stop_req = 1'b0;
      checks++; if (mode !== 2'd0 || note_out !== 16'h0200) begin
         errors++; $display("FAIL stop_abort: got mode %0d note %h want mode 0 note 0200", mode, note_out);
      end
      live_keys = '0;
      step(1);
   endtask

   task automatic test_saturation();
      int n_play;
      int n_bad;
      bit done;
      rec_req = 1'b1;
      step(1);
      rec_req = 1'b0;
      live_keys = 16'h0040;
      step(1100);
      stop_req = 1'b1;
      step(1);
      stop_req = 1'b0; live_keys = '0;
      checks++; if (rec_count !== 3'd2 || mode !== 2'd0) begin errors++; $display("FAIL sat_count: got count %0d mode %0d want 2 0", rec_count, mode); end
      step(1);
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      n_play = 0; n_bad = 0; done = 1'b0;
      for (int i = 0; i < 1200 && !done; i++) begin
         step(1);
         if (mode == 2'd2) begin
            n_play++;
            if (note_out !== 16'h0040) n_bad++;
         end else begin
            done = 1'b1;
         end
      end
      checks++; if (!done) begin errors++; $display("FAIL sat_timeout: playback still running after 1200 cycles"); end
      checks++; if (n_play != 1101) begin errors++; $display("FAIL sat_length: got %0d cycles want 1101", n_play); end
      checks++; if (n_bad != 0) begin errors++; $display("FAIL sat_note: got %0d wrong cycles want 0", n_bad); end
   endtask

   task automatic test_reset_mid_play();
      play_req = 1'b1;
      step(1);
      play_req = 1'b0;
      step(5);
      checks++; if (mode !== 2'd2) begin errors++; $display("FAIL midplay_mode: got %0d want 2", mode); end
      rst = 1'b1; play_req = 1'b1; rec_req = 1'b1; live_keys = 16'h0040;
      step(1);
      checks++; if (note_out !== 16'h0000) begin errors++; $display("FAIL rst_play_note: got %h want 0000", note_out); end
      checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_play_mode: got %0d want 0", mode); end
      checks++; if (rec_count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL rst_play_count: got count %0d full %b want 0 0", rec_count, full); end
      rst = 1'b0; play_req = 1'b0; rec_req = 1'b0; live_keys = '0;
      step(2);
   endtask

   initial begin
      test_reset();
      test_play_empty();
      test_record_replay();
      test_stop_priority();
      test_rest_multikey();
      test_note_rest_note();
      test_full();
      test_abort();
      test_saturation();
      test_reset_mid_play();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
